line_mem_responder: RTL
=======================

Name: line_mem_responder

Overview:
- Memory-side responder for the 128-bit line interface driven by the instruction and data caches (mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, mem_ready).
- Holds a small line-organised backing store and serves one line request at a time after a fixed programmable latency.
- Used as the slow-memory model behind the caches in the system bench, and as the on-chip line RAM in the synthesised top.

Parameters:
- BLOCK_WIDTH, 128, line width in bits.
- ADDR_WIDTH, 28, line address width (word address bits [29:2]).
- DEPTH_LOG2, 6, log2 of stored lines; lines indexed by mem_addr[DEPTH_LOG2-1:0], upper bits aliased.
- LATENCY, 4, cycles from request acceptance to mem_ready; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  line read request; held by the initiator until mem_ready.
- mem_write  in  1  line write request; held by the initiator until mem_ready.
- mem_addr  in  ADDR_WIDTH  line address.
- mem_wdata  in  BLOCK_WIDTH  write line data.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  BLOCK_WIDTH  read line data, valid only while mem_ready is high for a read.
- busy  out  1  high from acceptance through the mem_ready cycle.
- done_cnt  out  16  count of completed transactions, wraps at 65535 to 0.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. On a clk edge with rst=1: state=S_IDLE, latency counter=0, mem_ready=0, mem_rdata=0, busy=0, done_cnt=0. Storage array contents are not reset.
- States: S_IDLE, S_WAIT, S_RESP.
- S_IDLE: if mem_read|mem_write is sampled high, latch addr, wdata and op, load counter=LATENCY-1, go to S_WAIT (S_RESP directly if LATENCY=1). Otherwise stay.
- Both mem_read and mem_write high on acceptance: treat as write. No read data is returned.
- S_WAIT: decrement the counter each cycle. At 0, go to S_RESP.
- S_RESP: one cycle, mem_ready=1.
  - Read: mem_rdata = stored line at the latched index.
  - Write: the array is updated at the end of this cycle with latched wdata; mem_rdata=0.
  - done_cnt increments; next state is S_IDLE unconditionally.
- Timing: request first sampled at edge E gives mem_ready high in the cycle following edge E+LATENCY-1, i.e. exactly LATENCY cycles after the acceptance cycle.
- Inputs are latched at acceptance. Changes to mem_addr, mem_wdata, mem_read or mem_write during S_WAIT/S_RESP are ignored.
- The initiator drops its request in the mem_ready cycle (cache FETCH behaviour). The cycle after S_RESP is S_IDLE, and a still-asserted request there is accepted as a new transaction (back-to-back allowed, 1 idle cycle minimum between pulses).
- mem_rdata and mem_ready are registered outputs, with no combinational path from the inputs.
- Read-after-write to the same index returns the new data, because the write commits before any later S_RESP.
- Reset mid-transaction: the transaction is aborted, no array write occurs, done_cnt is not incremented, and mem_ready stays 0.
- Index aliasing: addresses differing only above bit DEPTH_LOG2-1 map to the same line; no error is flagged.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests for 10 cycles -> mem_ready=0, busy=0, mem_rdata=0, done_cnt=0 throughout.
- Write then read, LATENCY=4: write addr 0x0000005, wdata 0x0123..CDEF pattern, held until ready -> mem_ready exactly 4 cycles after acceptance. Next read of 0x0000005 -> mem_ready 4 cycles later with mem_rdata equal to the written pattern; done_cnt=2.
- Address hold: read 0x0000003 accepted, then mem_addr switched to 0x0000007 during S_WAIT -> returned data is line 3's contents.
- Simultaneous read+write to addr 0x09, wdata all-ones -> mem_rdata=0 in the ready cycle; a later read of 0x09 returns all-ones.
- Reset mid-op: write to 0x02 (prior contents 0xAA..AA) with rst pulsed in the second S_WAIT cycle -> no mem_ready, done_cnt=0, and a later read of 0x02 returns 0xAA..AA.
- Back-to-back plus alias, LATENCY=1: mem_read held continuously to 0x40 after writing 0x00 with pattern P -> mem_ready pulses every 2 cycles, each returning P (0x40 aliases 0x00 at DEPTH_LOG2=6).

Source files
------------

// File: rtl/line_mem_responder_if.sv
// Line-request bus between a cache (master) and the line memory (slave).
interface line_mem_responder_if #(
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH  = 28
);
  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [BLOCK_WIDTH-1:0] mem_wdata;
  logic                   mem_ready;
  logic [BLOCK_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/line_mem_responder.sv
// Line-organised backing store that answers one line request at a time after
// a fixed latency. Writes commit at the end of the response cycle; reads
// return the stored line registered into the response cycle.
module line_mem_responder #(
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                clk,
  input  logic                rst,
  line_mem_responder_if.slave bus,
  output logic                busy,
  output logic [15:0]         done_cnt
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam logic [7:0]  LatLoad = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   accept;

  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [BLOCK_WIDTH-1:0] wdata_q;
  logic                   wr_q;

  logic [DEPTH_LOG2-1:0]  resp_idx;
  logic                   resp_wr;

  logic                   ready_q;
  logic [BLOCK_WIDTH-1:0] rdata_q;
  logic [15:0]            done_q;

  logic [BLOCK_WIDTH-1:0] mem_q [Depth];

  // Upper address bits alias onto the same line and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];

  // Next-state logic: accept in idle, count down in wait, single response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_read || bus.mem_write) begin
          accept = 1'b1;
          if (LATENCY <= 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatLoad;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 8'd1;
        // Leave wait as the count expires so the response lands LATENCY cycles
        // after the acceptance cycle.
        if (cnt_q == 8'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= bus.mem_addr[DEPTH_LOG2-1:0];
      wdata_q <= bus.mem_wdata;
      wr_q    <= bus.mem_write;
    end
  end

  // With a single-cycle latency the response is formed straight from the inputs.
  always_comb begin
    resp_idx = idx_q;
    resp_wr  = wr_q;
    if (state_q == StIdle) begin
      resp_idx = bus.mem_addr[DEPTH_LOG2-1:0];
      resp_wr  = bus.mem_write;
    end
  end

  // Registered response outputs and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= 16'd0;
    end else begin
      ready_q <= (state_d == StResp);
      if (state_d == StResp && !resp_wr) begin
        rdata_q <= mem_q[resp_idx];
      end else begin
        rdata_q <= '0;
      end
      if (state_q == StResp) begin
        done_q <= done_q + 16'd1;
      end
    end
  end

  // Line store; a write commits at the end of its response cycle unless reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StResp && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign busy          = (state_q != StIdle);
  assign done_cnt      = done_q;

endmodule
